// File: rtl/fifo_pop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pop_scheduler
//  Description : Turns each qualified arbiter grant into a single one-cycle
//                pop on the granted FIFO, captures that FIFO's word one cycle
//                later, presents it downstream as a one-cycle valid strobe
//                and keeps a per-queue count of forwarded words.
//
//  Ports
//    clk               in   system clock, rising edge
//    rst               in   asynchronous active-high reset
//    enb               in   block enable (gates only the start of a transfer)
//    selector          in   granted queue index from the arbiter
//    selector_enb      in   grant valid
//    buf_empty         in   per-FIFO empty flags
//    fifo_data         in   FIFO output words, queue i at [i*DATA_BITS +: DATA_BITS]
//    down_almost_full  in   downstream backpressure, sampled at transfer start
//    pop               out  one-hot FIFO read strobe
//    data_out          out  forwarded word (registered)
//    valid_out         out  one-cycle strobe marking data_out valid
//    busy              out  high whenever the FSM is not idle
//    pkt_count         out  words forwarded per queue, queue i at [i*COUNT_BITS +: COUNT_BITS]
//
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_pop_scheduler #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int COUNT_BITS     = 8,
    localparam int SEL_BITS      = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enb,
    input  logic [SEL_BITS-1:0]                  selector,
    input  logic                                 selector_enb,
    input  logic [QUEUE_QUANTITY-1:0]            buf_empty,
    input  logic [QUEUE_QUANTITY*DATA_BITS-1:0]  fifo_data,
    input  logic                                 down_almost_full,
    output logic [QUEUE_QUANTITY-1:0]            pop,
    output logic [DATA_BITS-1:0]                 data_out,
    output logic                                 valid_out,
    output logic                                 busy,
    output logic [QUEUE_QUANTITY*COUNT_BITS-1:0] pkt_count
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [COUNT_BITS-1:0] c_cnt_one = COUNT_BITS'(1);

    state_t                              r_state;
    logic [SEL_BITS-1:0]                 r_sel_q;
    logic [DATA_BITS-1:0]                r_data_out;
    logic                                r_valid_out;
    logic [QUEUE_QUANTITY*COUNT_BITS-1:0] r_pkt_count;

    logic                                w_sel_avail;
    logic                                w_cur_empty;
    logic [DATA_BITS-1:0]                w_cur_data;
    logic                                w_grant;
    logic [QUEUE_QUANTITY-1:0]           w_pop;

    // ------------------------------------------------------------------
    // Grant qualification. The loop only covers real queues, so an
    // out-of-range selector never matches and reads as "no grant"; this
    // also avoids indexing buf_empty past its end.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_avail = 1'b0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (selector == SEL_BITS'(i)) begin
                w_sel_avail = ~buf_empty[i];
            end
        end
    end

    assign w_grant = enb & selector_enb & ~down_almost_full & w_sel_avail;

    // ------------------------------------------------------------------
    // Views of the queue currently in service
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_empty = 1'b1;
        w_cur_data  = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (r_sel_q == SEL_BITS'(i)) begin
                w_cur_empty = buf_empty[i];
                w_cur_data  = fifo_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pop strobe: combinational from the POP state so the FIFO sees the
    // read in the same cycle. Suppressed if the queue drained between the
    // grant and now, so an empty FIFO is never read.
    // ------------------------------------------------------------------
    always_comb begin
        w_pop = '0;
        if (r_state == ST_POP && !w_cur_empty) begin
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                if (r_sel_q == SEL_BITS'(i)) begin
                    w_pop[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer. valid_out defaults low every cycle so it can only ever be
    // a single-cycle pulse; enb and down_almost_full only influence the
    // decision to start, never a transfer already in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel_q     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_valid_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_sel_q <= selector;
                        r_state <= ST_POP;
                    end
                end

                ST_POP: begin
                    // Queue went empty under us: nothing was read, abandon.
                    if (w_cur_empty) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    // FIFO word popped last cycle is valid now.
                    r_data_out  <= w_cur_data;
                    r_valid_out <= 1'b1;
                    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                        if (r_sel_q == SEL_BITS'(i)) begin
                            r_pkt_count[i*COUNT_BITS +: COUNT_BITS] <=
                                r_pkt_count[i*COUNT_BITS +: COUNT_BITS] + c_cnt_one;
                        end
                    end
                    // Back-to-back: the next pop overlaps this capture.
                    if (w_grant) begin
                        r_sel_q <= selector;
                        r_state <= ST_POP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pop       = w_pop;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign busy      = (r_state != ST_IDLE);
    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_pop_scheduler
//  Description : Directed self-checking bench for fifo_pop_scheduler.
//                Inputs change and outputs are sampled 1 ns after each
//                rising clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_pop_scheduler;

    localparam int c_qq = 4;
    localparam int c_db = 8;
    localparam int c_cb = 8;

    logic                  clk;
    logic                  rst;
    logic                  enb;
    logic [1:0]            selector;
    logic                  selector_enb;
    logic [c_qq-1:0]       buf_empty;
    logic [c_qq*c_db-1:0]  fifo_data;
    logic                  down_almost_full;
    logic [c_qq-1:0]       pop;
    logic [c_db-1:0]       data_out;
    logic                  valid_out;
    logic                  busy;
    logic [c_qq*c_cb-1:0]  pkt_count;

    int n_tests;
    int n_fail;

    logic [7:0] qword [4];

    fifo_pop_scheduler #(
        .QUEUE_QUANTITY (c_qq),
        .DATA_BITS      (c_db),
        .COUNT_BITS     (c_cb)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .enb              (enb),
        .selector         (selector),
        .selector_enb     (selector_enb),
        .buf_empty        (buf_empty),
        .fifo_data        (fifo_data),
        .down_almost_full (down_almost_full),
        .pop              (pop),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .busy             (busy),
        .pkt_count        (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        qword[0] = 8'h11;
        qword[1] = 8'h22;
        qword[2] = 8'hA5;
        qword[3] = 8'h44;

        // ---------------- reset state + single transfer from queue 2 ------
        rst              = 1'b1;
        enb              = 1'b1;
        selector         = 2'd2;
        selector_enb     = 1'b1;
        buf_empty        = 4'b0000;
        fifo_data        = 32'h44A5_2211;
        down_almost_full = 1'b0;
        tick();
        tick();
        check("rst_pop",   32'(pop),       32'h0);
        check("rst_data",  32'(data_out),  32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_cnt",   pkt_count,      32'h0);
        rst = 1'b0;
        tick();                                   // E0: grant sampled
        check("t1_pop",    32'(pop),  32'h4);
        check("t1_busy",   32'(busy), 32'h1);
        selector_enb = 1'b0;
        tick();                                   // E1: capture pending
        check("t1_pop_off", 32'(pop),       32'h0);
        check("t1_nvalid",  32'(valid_out), 32'h0);
        tick();                                   // E2: word registered
        check("t1_data",   32'(data_out),  32'hA5);
        check("t1_valid",  32'(valid_out), 32'h1);
        check("t1_cnt",    pkt_count,      32'h0001_0000);
        check("t1_idle",   32'(busy),      32'h0);
        tick();
        check("t1_valid_pulse", 32'(valid_out), 32'h0);

        // ---------------- back-to-back round robin 0..3 ------------------
        do_reset();
        selector     = 2'd0;
        selector_enb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();                               // pop cycle for queue k
            check("rr_pop", 32'(pop), 32'(1 << k));
            check("rr_valid", 32'(valid_out), (k > 0) ? 32'h1 : 32'h0);
            if (k > 0) check("rr_data", 32'(data_out), 32'(qword[k-1]));
            selector = 2'(k + 1);
            tick();                               // capture-pending cycle
            check("rr_pop_gap",   32'(pop),       32'h0);
            check("rr_valid_gap", 32'(valid_out), 32'h0);
            if (k == 3) selector_enb = 1'b0;
        end
        tick();
        check("rr_last_data",  32'(data_out),  32'h44);
        check("rr_last_valid", 32'(valid_out), 32'h1);
        check("rr_cnt",        pkt_count,      32'h0101_0101);

        // ---------------- all FIFOs empty --------------------------------
        do_reset();
        buf_empty    = 4'b1111;
        selector     = 2'd1;
        selector_enb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("empty_pop",   32'(pop),       32'h0);
            check("empty_valid", 32'(valid_out), 32'h0);
            check("empty_busy",  32'(busy),      32'h0);
        end
        check("empty_cnt", pkt_count, 32'h0);

        // ---------------- queue drains during POP ------------------------
        buf_empty = 4'b0000;
        selector  = 2'd3;
        tick();
        check("abort_pop_pre", 32'(pop), 32'h8);
        buf_empty    = 4'b1000;
        selector_enb = 1'b0;
        #1;
        check("abort_pop_supp", 32'(pop), 32'h0);
        tick();
        check("abort_idle",  32'(busy),      32'h0);
        check("abort_valid", 32'(valid_out), 32'h0);
        tick();
        check("abort_valid2", 32'(valid_out), 32'h0);
        check("abort_cnt",    pkt_count,      32'h0);

        // ---------------- backpressure / enable --------------------------
        buf_empty        = 4'b0000;
        selector         = 2'd0;
        selector_enb     = 1'b1;
        down_almost_full = 1'b1;
        tick();
        check("daf_block_pop",  32'(pop),  32'h0);
        tick();
        check("daf_block_busy", 32'(busy), 32'h0);
        down_almost_full = 1'b0;
        tick();
        check("daf_start_pop", 32'(pop), 32'h1);
        down_almost_full = 1'b1;
        enb              = 1'b0;
        tick();
        check("daf_inflight_busy", 32'(busy), 32'h1);
        tick();
        check("daf_complete_valid", 32'(valid_out), 32'h1);
        check("daf_complete_data",  32'(data_out),  32'h11);
        check("daf_complete_idle",  32'(busy),      32'h0);
        tick();
        check("daf_stall_busy",  32'(busy),      32'h0);
        check("daf_stall_valid", 32'(valid_out), 32'h0);
        check("daf_cnt",         pkt_count,      32'h0000_0001);
        enb              = 1'b1;
        down_almost_full = 1'b0;
        selector_enb     = 1'b0;

        // ---------------- 256 transfers from queue 1: counter wrap -------
        do_reset();
        selector     = 2'd1;
        selector_enb = 1'b1;
        repeat (510) tick();
        tick();                                   // 255th capture
        check("wrap_255", pkt_count, 32'h0000_FF00);
        tick();
        selector_enb = 1'b0;
        tick();                                   // 256th capture
        check("wrap_0",     pkt_count,      32'h0);
        check("wrap_valid", 32'(valid_out), 32'h1);
        check("wrap_data",  32'(data_out),  32'h22);

        // ---------------- asynchronous reset mid-POP ---------------------
        selector     = 2'd2;
        selector_enb = 1'b1;
        tick();
        check("arst_pre_pop", 32'(pop), 32'h4);
        selector_enb = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_pop",   32'(pop),       32'h0);
        check("arst_busy",  32'(busy),      32'h0);
        check("arst_data",  32'(data_out),  32'h0);
        check("arst_valid", 32'(valid_out), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_stay_idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_pop_scheduler.md
# fifo_pop_scheduler

Sequencing controller between the weighted round-robin arbiter and the input FIFO bank. It turns each arbiter grant (`selector`/`selector_enb`) into a single one-cycle pop on the granted FIFO and captures that FIFO's word one cycle later. It then presents the word downstream as a one-cycle `valid_out` strobe, honouring downstream backpressure, and keeps a per-queue count of words forwarded.

## Interface
- `QUEUE_QUANTITY`, 4: number of FIFOs/requesters.
- `DATA_BITS`, 8: FIFO word width.
- `COUNT_BITS`, 8: width of each per-queue forwarded-word counter.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enb`  in  1  block enable; gates only the start of a new transfer.
- `selector`  in  $clog2(QUEUE_QUANTITY)  granted queue index from the arbiter.
- `selector_enb`  in  1  grant valid.
- `buf_empty`  in  QUEUE_QUANTITY  per-FIFO empty flags.
- `fifo_data`  in  QUEUE_QUANTITY*DATA_BITS  FIFO output words; queue i at `[i*DATA_BITS +: DATA_BITS]`.
- `down_almost_full`  in  1  downstream backpressure; no new transfer starts while high.
- `pop`  out  QUEUE_QUANTITY  one-hot FIFO read strobe.
- `data_out`  out  DATA_BITS  forwarded word (registered).
- `valid_out`  out  1  one-cycle strobe marking `data_out` valid.
- `busy`  out  1  high whenever state is not IDLE.
- `pkt_count`  out  QUEUE_QUANTITY*COUNT_BITS  words forwarded per queue; queue i at `[i*COUNT_BITS +: COUNT_BITS]`.

## Operation
- FSM has 3 states: IDLE, POP, CAPTURE. Register `sel_q` holds the queue in service.
- A grant qualifies when all of these hold: `enb`, `selector_enb`, `selector` < `QUEUE_QUANTITY`, `buf_empty[selector]` = 0, and `down_almost_full` = 0.
- IDLE:
  - Qualifying grant: latch `sel_q` <= `selector`, go to POP.
  - Otherwise: stay in IDLE.
- POP:
  - `pop[sel_q]` = 1 combinationally. The pop is suppressed if `buf_empty[sel_q]` = 1.
  - If `buf_empty[sel_q]` = 1: abort to IDLE. No capture, no count.
  - Otherwise: go to CAPTURE.
- CAPTURE:
  - On the edge: `data_out` <= `fifo_data[sel_q]`, `valid_out` <= 1, and `pkt_count[sel_q]` increments.
  - If a grant qualifies in this same cycle: latch the new `sel_q`, go directly to POP (back-to-back).
  - Otherwise: go to IDLE.
- `enb` low blocks only IDLE->POP and CAPTURE->POP. A transfer already in POP/CAPTURE always completes so popped data is never lost.
- `down_almost_full` is sampled only at transfer start. A transfer in flight always completes.
- Out-of-range `selector` (non-power-of-2 `QUEUE_QUANTITY`) is treated as no grant.
- `pkt_count` fields wrap modulo 2^`COUNT_BITS`, independently per queue.
- Reset (async, any state): FSM -> IDLE, `sel_q` = 0, `pop` = 0, `data_out` = 0, `valid_out` = 0, `busy` = 0, all `pkt_count` = 0. A pop in flight is dropped, and the word is lost by design.

## Timing
- Edge E0 samples a qualifying grant (IDLE->POP).
- Cycle E0..E1: `pop` is high for exactly one cycle.
- FIFO data is valid during cycle E1..E2 (one-cycle FIFO read latency).
- E2 registers the data. `valid_out` is high during E2..E3 only.
- Grant-to-`valid_out` latency is 2 edges. Sustained throughput is one word per 2 cycles.
- `pop` is never high in two consecutive cycles, and never more than one bit at a time.
- `valid_out` deasserts on the edge after it rises, unless a back-to-back transfer completes on that edge (it cannot; minimum spacing is 2 cycles).
- `busy` is high from E0 to the edge returning to IDLE.
- `rst` deasserts synchronously with respect to bench stimulus; the first grant is sampled on the first edge after release.

## Test plan
- Reset release with `selector`=2, `selector_enb`=1, all FIFOs non-empty, `fifo_data` queue2 = 8'hA5 -> `pop`=4'b0100 for one cycle; 2 edges later `data_out`=8'hA5 with `valid_out` pulsed once; `pkt_count[2]`=1.
- Grant held continuously with selector cycling 0,1,2,3 -> `pop` pulses 0001, 0010, 0100, 1000 every 2 cycles; each `pkt_count` field = 1 after 8 cycles; `valid_out` is never high on adjacent cycles.
- `buf_empty`=4'b1111 with grants active -> `pop`=0, `valid_out`=0, `busy`=0 throughout; all counts stay at 0.
- `buf_empty[sel_q]` rises during POP -> `pop`=0 that cycle, FSM returns to IDLE, no `valid_out`, count unchanged.
- `down_almost_full`=1 at grant -> no transfer starts. Raising `down_almost_full` or dropping `enb` during POP -> the transfer still completes with a `valid_out` pulse, then the block stalls in IDLE.
- 256 transfers from queue 1 with `COUNT_BITS`=8 -> `pkt_count[1]` wraps to 0. Async `rst` mid-POP -> all outputs 0 immediately, before the next clock edge.
